// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of NUM_Q upstream FIFOs into one valid/ready stream, with a per-grant burst cap.
// Optional macro FIFO_RR_SCHED_PRIO_EN gives queue 0 strict priority over the rotation.
module fifo_rr_scheduler #(
    parameter int NUM_Q     = 4,
    parameter int BIT_WIDTH = 32,
    parameter int BURST_LEN = 4,
    localparam int QID_W    = $clog2(NUM_Q)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en,
    input  logic [NUM_Q-1:0]           fifo_empty,
    output logic [NUM_Q-1:0]           fifo_re,
    input  logic [NUM_Q*BIT_WIDTH-1:0] fifo_dout,
    input  logic [NUM_Q-1:0]           fifo_ovalid,
    output logic [BIT_WIDTH-1:0]       m_data,
    output logic [QID_W-1:0]           m_qid,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       sched_busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [1:0]           state_reg, state_next;
    logic [QID_W-1:0]     grant_reg, grant_next;
    logic [QID_W-1:0]     last_grant_reg, last_grant_next;
    logic [BEAT_W-1:0]    beat_reg, beat_next;
    logic [BIT_WIDTH-1:0] m_data_reg, m_data_next;
    logic [QID_W-1:0]     m_qid_reg, m_qid_next;
    logic                 m_valid_reg, m_valid_next;

    logic [BIT_WIDTH-1:0] dout_arr [NUM_Q];
    logic                 found;
    logic [QID_W-1:0]     pick;
    logic                 handshake;
    logic                 prio_preempt;
    logic                 burst_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_Q; gi++) begin : g_lane
            assign dout_arr[gi] = fifo_dout[gi*BIT_WIDTH +: BIT_WIDTH];
            assign fifo_re[gi]  = (state_reg == ISSUE) && (grant_reg == QID_W'(gi));
        end
    endgenerate

    // Rotating search: the queue just after last_grant has the highest priority.
    always_comb begin : search
        int               idx;
        logic [QID_W-1:0] idx_q;
        idx   = 0;
        idx_q = '0;
        found = 1'b0;
        pick  = '0;
`ifdef FIFO_RR_SCHED_PRIO_EN
        if (!fifo_empty[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_Q; k++) begin
            idx   = (int'(last_grant_reg) + k) % NUM_Q;
            idx_q = QID_W'(idx);
            if (!found && !fifo_empty[idx_q]) begin
                found = 1'b1;
                pick  = idx_q;
            end
        end
    end

`ifdef FIFO_RR_SCHED_PRIO_EN
    assign prio_preempt = (grant_reg != '0) && !fifo_empty[0];
`else
    assign prio_preempt = 1'b0;
`endif

    assign handshake  = (state_reg == PRESENT) && m_valid_reg && m_ready;
    assign burst_done = (beat_reg == BEAT_W'(BURST_LEN - 1)) || fifo_empty[grant_reg]
                        || !sched_en || prio_preempt;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_next       = beat_reg;
        m_data_next     = m_data_reg;
        m_qid_next      = m_qid_reg;
        m_valid_next    = m_valid_reg;
        case (state_reg)
            IDLE: begin
                if (sched_en && found) begin
                    grant_next = pick;
                    beat_next  = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = CAPTURE;
            CAPTURE: begin
                // Only the granted queue's read-valid matters; others may toggle freely.
                if (fifo_ovalid[grant_reg]) begin
                    m_data_next  = dout_arr[grant_reg];
                    m_qid_next   = grant_reg;
                    m_valid_next = 1'b1;
                    state_next   = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    m_valid_next = 1'b0;
                    beat_next    = beat_reg + 1'b1;
                    if (burst_done) begin
                        state_next      = IDLE;
                        last_grant_next = grant_reg;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= QID_W'(NUM_Q - 1);
            beat_reg       <= '0;
            m_data_reg     <= '0;
            m_qid_reg      <= '0;
            m_valid_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_reg       <= beat_next;
            m_data_reg     <= m_data_next;
            m_qid_reg      <= m_qid_next;
            m_valid_reg    <= m_valid_next;
        end
    end

    assign m_data     = m_data_reg;
    assign m_qid      = m_qid_reg;
    assign m_valid    = m_valid_reg;
    assign sched_busy = (state_reg != IDLE);
endmodule
